// File: rtl/fp_sq.sv
// Iterative IEEE-754 single-precision squarer (out = in1 * in1) using a 1-bit/cycle shift-add multiplier.
// Optional build macro FP_SQ_EARLY_EXIT_EN: skip trailing-zero multiplier bits and exit MUL once the remaining bits are zero.
`ifndef RNe
`define RNe 3'b000
`endif
`ifndef RZ
`define RZ 3'b001
`endif
`ifndef RD
`define RD 3'b010
`endif
`ifndef RU
`define RU 3'b011
`endif
`ifndef RNa
`define RNa 3'b100
`endif

module fp_sq #(
  parameter int W = 32,
  parameter int M = 22,
  parameter int E = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         act,
  input  logic [W-1:0] in1,
  input  logic [2:0]   round_m,
  output logic [W-1:0] out,
  output logic         done,
  output logic         ov,
  output logic         un,
  output logic         inv,
  output logic         inexact
);
  // state | meaning
  // IDLE  | waiting for act
  // SPEC  | NaN/Inf/zero/subnormal operand, result decided directly
  // MUL   | shift-add mantissa square, one multiplier bit per cycle
  // NORM  | pick fraction, guard and sticky from the product
  // ROUND | apply rounding mode, detect overflow/underflow, register result
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SPEC  = 3'd1;
  localparam logic [2:0] MUL   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] ROUND = 3'd4;

  localparam int FW = M + 1;
  localparam int MW = M + 2;
  localparam int PW = 2 * MW;

  localparam logic [W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [W-1:0] INF     = 32'h7F80_0000;
  localparam logic [W-1:0] MAXF    = 32'h7F7F_FFFF;
  localparam logic [W-1:0] MINN    = 32'h0080_0000;

  logic [2:0]    state;
  logic [E:0]    op;
  logic [2:0]    rm;
  logic [MW-1:0] mant;
  logic [PW-1:0] acc;
  logic [4:0]    cnt;
  logic [FW-1:0] frac_n;
  logic          g_n, s_n;
  logic signed [9:0] eb_n;

  logic          unused_sign;
  assign unused_sign = in1[W-1];

  logic in_special;
  assign in_special = (in1[E:M+1] == '1) || (in1[E:M+1] == '0);

  logic [4:0] start_cnt;
  logic       mul_last;
`ifdef FP_SQ_EARLY_EXIT_EN
  logic [MW-1:0] m_in;
  logic          found;
  assign m_in = {1'b1, in1[M:0]};
  always_comb begin
    start_cnt = '0;
    found     = 1'b0;
    for (int i = 0; i < MW; i++) begin
      if (!found && m_in[i]) begin
        start_cnt = 5'(i);
        found     = 1'b1;
      end
    end
  end
  assign mul_last = (cnt == 5'(MW-1)) || ((mant >> (cnt + 5'd1)) == '0);
`else
  assign start_cnt = '0;
  assign mul_last  = (cnt == 5'(MW-1));
`endif

  logic signed [9:0] eb_base;
  assign eb_base = $signed({1'b0, op[E:M+1], 1'b0}) - 10'sd127;

  logic          rnd_inc;
  logic          carry;
  logic [FW-1:0] frac_r;
  logic signed [9:0] eb_r;
  logic          ov_c, un_c;
  always_comb begin
    rnd_inc = 1'b0;
    case (rm)
      `RNe:    rnd_inc = g_n & (s_n | frac_n[0]);
      `RNa:    rnd_inc = g_n;
      `RU:     rnd_inc = g_n | s_n;
      default: rnd_inc = 1'b0;
    endcase
    {carry, frac_r} = {1'b0, frac_n} + {{FW{1'b0}}, rnd_inc};
    eb_r = eb_n + $signed({9'b0, carry});
    ov_c = eb_r > 10'sd254;
    un_c = eb_r < 10'sd1;
  end

  logic op_nan;
  assign op_nan = (op[E:M+1] == '1) && (op[M:0] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op      <= '0;
      rm      <= '0;
      mant    <= '0;
      acc     <= '0;
      cnt     <= '0;
      frac_n  <= '0;
      g_n     <= 1'b0;
      s_n     <= 1'b0;
      eb_n    <= '0;
      out     <= '0;
      done    <= 1'b0;
      ov      <= 1'b0;
      un      <= 1'b0;
      inv     <= 1'b0;
      inexact <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (act) begin
            op   <= in1[E:0];
            rm   <= round_m;
            mant <= {1'b1, in1[M:0]};
            acc  <= '0;
            cnt  <= start_cnt;
            state <= in_special ? SPEC : MUL;
          end
        end
        SPEC: begin
          done    <= 1'b1;
          ov      <= 1'b0;
          un      <= 1'b0;
          inv     <= 1'b0;
          inexact <= 1'b0;
          if (op_nan) begin
            out <= QNAN;
            inv <= ~op[M];
          end else if (op[E:M+1] == '1) begin
            out <= INF;
          end else if (op[M:0] == '0) begin
            out <= '0;
          end else begin
            // subnormal squares are far below the normal range
            out     <= (rm == `RU) ? MINN : '0;
            un      <= 1'b1;
            inexact <= 1'b1;
          end
          state <= IDLE;
        end
        MUL: begin
          if (mant[cnt])
            acc <= acc + ({{MW{1'b0}}, mant} << cnt);
          if (mul_last)
            state <= NORM;
          else
            cnt <= cnt + 5'd1;
        end
        NORM: begin
          if (acc[PW-1]) begin
            frac_n <= acc[PW-2 -: FW];
            g_n    <= acc[PW-2-FW];
            s_n    <= |acc[PW-3-FW:0];
            eb_n   <= eb_base + 10'sd1;
          end else begin
            frac_n <= acc[PW-3 -: FW];
            g_n    <= acc[PW-3-FW];
            s_n    <= |acc[PW-4-FW:0];
            eb_n   <= eb_base;
          end
          state <= ROUND;
        end
        ROUND: begin
          done <= 1'b1;
          inv  <= 1'b0;
          if (ov_c) begin
            out     <= (rm == `RZ || rm == `RD) ? MAXF : INF;
            ov      <= 1'b1;
            un      <= 1'b0;
            inexact <= 1'b1;
          end else if (un_c) begin
            out     <= (rm == `RU) ? MINN : '0;
            ov      <= 1'b0;
            un      <= 1'b1;
            inexact <= 1'b1;
          end else begin
            out     <= {1'b0, eb_r[7:0], frac_r};
            ov      <= 1'b0;
            un      <= 1'b0;
            inexact <= g_n | s_n;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_sq.sv
// Scoreboard bench for fp_sq: directed operands with hand-computed squares, flags and latency.
`ifndef RNe
`define RNe 3'b000
`endif
`ifndef RZ
`define RZ 3'b001
`endif
`ifndef RD
`define RD 3'b010
`endif
`ifndef RU
`define RU 3'b011
`endif
`ifndef RNa
`define RNa 3'b100
`endif

module tb_fp_sq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        act = 1'b0;
  logic [31:0] in1 = '0;
  logic [2:0]  round_m = '0;
  logic [31:0] out;
  logic        done, ov, un, inv, inexact;

  fp_sq #(.W(32), .M(22), .E(30)) dut (
    .clk(clk), .rst(rst), .act(act), .in1(in1), .round_m(round_m),
    .out(out), .done(done), .ov(ov), .un(un), .inv(inv), .inexact(inexact)
  );

  always #5 clk = ~clk;

`ifdef FP_SQ_EARLY_EXIT_EN
  localparam int LN = 0;
`else
  localparam int LN = 27;
`endif

  typedef struct {
    logic [31:0] o;
    logic [3:0]  fl;
    int          issue;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [31:0] hold_out;
  logic [3:0]  hold_fl;

  always @(posedge clk) cyc++;

  // flags packed as {ov, un, inv, inexact}
  always @(negedge clk) begin
    if (rst) begin
      hold_out = '0;
      hold_fl  = '0;
    end else if (done) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: out=%h with nothing pending at cycle %0d", out, cyc);
      end else begin
        e = sb.pop_front();
        total++;
        if (out !== e.o) begin
          bad++;
          $display("FAIL result: got %h expected %h", out, e.o);
        end
        total++;
        if ({ov, un, inv, inexact} !== e.fl) begin
          bad++;
          $display("FAIL flags(%h): got %b expected %b", e.o, {ov, un, inv, inexact}, e.fl);
        end
        if (e.lat != 0) begin
          total++;
          if (cyc - e.issue != e.lat) begin
            bad++;
            $display("FAIL latency(%h): got %0d expected %0d", e.o, cyc - e.issue, e.lat);
          end
        end
        hold_out = e.o;
        hold_fl  = e.fl;
      end
    end else begin
      total++;
      if (out !== hold_out || {ov, un, inv, inexact} !== hold_fl) begin
        bad++;
        $display("FAIL hold: got %h/%b expected %h/%b", out, {ov, un, inv, inexact}, hold_out, hold_fl);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [2:0] rm,
                       input logic [31:0] eo, input logic [3:0] efl, input int lat);
    exp_t x;
    @(posedge clk); #2;
    x.o = eo; x.fl = efl; x.issue = cyc; x.lat = lat;
    sb.push_back(x);
    in1 = a; round_m = rm; act = 1'b1;
    @(posedge clk); #2;
    act = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] a, input logic [2:0] rm);
    in1 = a; round_m = rm; act = 1'b1;
    @(posedge clk); #2;
    act = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout: %0d results still pending", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [2:0]  rm;
    logic [31:0] eo;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{32'h4040_0000, `RNe, 32'h4110_0000, 4'b0000, LN},
      '{32'h3F8C_CCCD, `RNe, 32'h3F9A_E148, 4'b0001, LN},
      '{32'h3F8C_CCCD, `RU,  32'h3F9A_E149, 4'b0001, LN},
      '{32'h3F8C_CCCD, `RZ,  32'h3F9A_E148, 4'b0001, LN},
      '{32'h3F8C_CCCD, `RD,  32'h3F9A_E148, 4'b0001, LN},
      '{32'h3F8C_CCCD, `RNa, 32'h3F9A_E148, 4'b0001, LN},
      '{32'hC000_0000, `RNe, 32'h4080_0000, 4'b0000, LN},
      '{32'h8000_0000, `RNe, 32'h0000_0000, 4'b0000, 2},
      '{32'h7F00_0000, `RNe, 32'h7F80_0000, 4'b1001, LN},
      '{32'h7F00_0000, `RZ,  32'h7F7F_FFFF, 4'b1001, LN},
      '{32'h7F00_0000, `RU,  32'h7F80_0000, 4'b1001, LN},
      '{32'h7F00_0000, `RD,  32'h7F7F_FFFF, 4'b1001, LN},
      '{32'h5F80_0000, `RNe, 32'h7F80_0000, 4'b1001, LN},
      '{32'h5F7F_FFFF, `RNe, 32'h7F7F_FFFE, 4'b0001, LN},
      '{32'h5F7F_FFFF, `RU,  32'h7F7F_FFFF, 4'b0001, LN},
      '{32'h1F80_0000, `RNe, 32'h0000_0000, 4'b0101, LN},
      '{32'h1F80_0000, `RU,  32'h0080_0000, 4'b0101, LN},
      '{32'h2000_0000, `RNe, 32'h0080_0000, 4'b0000, LN},
      '{32'h7FA0_0000, `RNe, 32'h7FC0_0000, 4'b0010, 2},
      '{32'h7FC0_0000, `RNe, 32'h7FC0_0000, 4'b0000, 2},
      '{32'hFF80_0000, `RNe, 32'h7F80_0000, 4'b0000, 2},
      '{32'h0000_0001, `RNe, 32'h0000_0000, 4'b0101, 2},
      '{32'h807F_FFFF, `RU,  32'h0080_0000, 4'b0101, 2}
    };

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (out !== 32'h0 || done !== 1'b0 || {ov, un, inv, inexact} !== 4'b0) begin
      bad++;
      $display("FAIL reset_state: out=%h done=%b flags=%b expected all zero", out, done, {ov, un, inv, inexact});
    end

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].rm, vecs[i].eo, vecs[i].fl, vecs[i].lat);
      wait_idle();
    end

    // extra act mid-operation must not start a second square
    issue(32'h4040_0000, `RNe, 32'h4110_0000, 4'b0000, LN);
    repeat (5) @(posedge clk);
    #2 pulse(32'h3FC0_0000, `RNe);
    wait_idle();
    repeat (30) @(posedge clk);
    #2;

    // asynchronous reset in the middle of MUL aborts without a done
    pulse(32'h4040_0000, `RNe);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (out !== 32'h0 || done !== 1'b0 || {ov, un, inv, inexact} !== 4'b0) begin
      bad++;
      $display("FAIL async_reset: out=%h done=%b flags=%b expected all zero", out, done, {ov, un, inv, inexact});
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    issue(32'h3FC0_0000, `RNe, 32'h4010_0000, 4'b0000, LN);
    wait_idle();

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
